alu_issue_ctrl: RTL and testbench

- Sequential initiator for the team's 8-bit combinational ALU (ADD/SUB/AND/OR/XOR/NOR, opcodes 000-101).
- Accepts register-to-register instructions over a valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU operand/opcode inputs, captures the ALU result and zero flag, writes back, and reports completion.
- Sits between the instruction source and the ALU instance.

---
 rtl/alu_issue_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Sequential issue controller for the 8-bit combinational ALU.
// One instruction is in flight at a time. It moves IDLE -> EXEC -> WB -> IDLE,
// so each instruction occupies the controller for exactly three cycles.
//
//   IDLE : Accepts an instruction over instr_valid/instr_ready. On the accept
//          edge it reads both operands from the register file and registers
//          them, together with the opcode, onto the ALU inputs.
//   EXEC : The ALU inputs are held stable for the whole cycle. The ALU result
//          and zero flag are captured on the closing edge.
//   WB   : Retires the instruction. For a legal opcode it writes the register
//          file and updates flag_zero and done_data. For an illegal opcode it
//          writes nothing, clears done_data and raises err_op. done pulses
//          for one cycle in both cases.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   instr_valid     instruction present
//   instr_ready     controller can accept (IDLE and not in reset)
//   instr_op        ALU opcode to issue
//   instr_rd        destination register
//   instr_rs1       source register driven to alu_a
//   instr_rs2       source register driven to alu_b
//   ld_en           direct register-file write strobe, honoured in any state
//   ld_addr         register written by ld_en
//   ld_data         data written by ld_en
//   alu_a, alu_b    registered operands to the ALU
//   alu_opcode      registered opcode to the ALU
//   alu_result      combinational ALU result
//   alu_zero        combinational ALU zero flag
//   done            one-cycle retire pulse
//   done_data       result of the last retired instruction
//   flag_zero       zero flag of the last legal retired instruction
//   err_op          one-cycle pulse with done for opcodes 110/111
//   busy            controller not in IDLE
//   dbg_addr        debug read index
//   dbg_data        combinational read of the register selected by dbg_addr
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,

    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WIDTH-1:0]  ld_data,

    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero,

    output logic              done,
    output logic [WIDTH-1:0]  done_data,
    output logic              flag_zero,
    output logic              err_op,
    output logic              busy,

    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int NREG = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0]  regs [NREG];

    // Instruction context latched at accept (stage 0) and ALU capture (stage 1).
    logic [ADDR_W-1:0] rd_p0;
    logic [2:0]        op_p0;
    logic [WIDTH-1:0]  res_p1;
    logic              zero_p1;

    logic              accept;
    logic              wb_legal;
    logic              wb_illegal;

    // The ALU defines opcodes 000-101. 110 and 111 are issued anyway but retire
    // as errors.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

    // -----------------------------------------------------------------------
    // FSM next-state and handshake
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = !rst;
                if (instr_valid && !rst) begin
                    state_d = EXEC;
                end
            end
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept     = instr_valid && instr_ready;
    assign wb_legal   = (state_q == WB) &&  op_is_legal(op_p0);
    assign wb_illegal = (state_q == WB) && !op_is_legal(op_p0);
    assign busy       = (state_q != IDLE);
    assign dbg_data   = regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 0: accept edge -- operands read with pre-edge register values
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rd_p0      <= '0;
            op_p0      <= '0;
        end else if (accept) begin
            alu_a      <= regs[instr_rs1];
            alu_b      <= regs[instr_rs2];
            alu_opcode <= instr_op;
            rd_p0      <= instr_rd;
            op_p0      <= instr_op;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: close of EXEC -- capture ALU result and zero flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            res_p1  <= '0;
            zero_p1 <= 1'b0;
        end else if (state_q == EXEC) begin
            res_p1  <= alu_result;
            zero_p1 <= alu_zero;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: close of WB -- retire, report status
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            err_op    <= 1'b0;
            done_data <= '0;
            flag_zero <= 1'b0;
        end else begin
            done   <= (state_q == WB);
            err_op <= wb_illegal;
            if (wb_legal) begin
                done_data <= res_p1;
                flag_zero <= zero_p1;
            end else if (wb_illegal) begin
                done_data <= '0;
            end
        end
    end

    // Register file. The write-back assignment comes after the ld_en one, so on
    // a same-edge, same-address collision the instruction result is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ld_en) begin
                regs[ld_addr] <= ld_data;
            end
            if (wb_legal) begin
                regs[rd_p0] <= res_p1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl, with a behavioural model of the 8-bit ALU.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [1:0] instr_rd, instr_rs1, instr_rs2;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       done;
    logic [7:0] done_data;
    logic       flag_zero;
    logic       err_op;
    logic       busy;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    alu_issue_ctrl #(.WIDTH(8), .ADDR_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .done        (done),
        .done_data   (done_data),
        .flag_zero   (flag_zero),
        .err_op      (err_op),
        .busy        (busy),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // ALU model
    always_comb begin
        case (alu_opcode)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = alu_a ^ alu_b;
            3'd5:    alu_result = ~(alu_a | alu_b);
            default: alu_result = 8'h00;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [1:0] rd, rs1, rs2;
        logic [7:0] a, b;
        logic [7:0] res;
        logic       zf;
        logic       err;
        logic [7:0] rdval;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [7:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic ld(input logic [1:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [1:0] rd,
                             input logic [1:0] rs1, input logic [1:0] rs2);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
    endtask

    task automatic run_vec(input int i);
        int         lat;
        logic [7:0] v;
        string      n;
        n = vecs[i].name;
        set_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
        check({n, " ready_before"}, instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        check({n, " alu_a"}, alu_a, vecs[i].a);
        check({n, " alu_b"}, alu_b, vecs[i].b);
        check({n, " alu_opcode"}, alu_opcode, vecs[i].op);
        check({n, " busy_exec"}, busy, 1);
        check({n, " ready_exec"}, instr_ready, 0);
        lat = 0;
        while (!done && lat < 6) begin
            tick();
            lat++;
        end
        check({n, " latency"}, lat, 2);
        check({n, " done_data"}, done_data, vecs[i].res);
        check({n, " err_op"}, err_op, vecs[i].err);
        check({n, " flag_zero"}, flag_zero, vecs[i].zf);
        rd_reg(vecs[i].rd, v);
        check({n, " rd_value"}, v, vecs[i].rdval);
        tick();
        check({n, " done_one_cycle"}, done, 0);
        check({n, " ready_after"}, instr_ready, 1);
    endtask

    initial begin
        logic [7:0] v;
        logic       saw_done;

        //                name          op    rd    rs1   rs2   a      b      res    zf    err   rdval
        vecs[0] = '{"add_r3",   3'd0, 2'd3, 2'd1, 2'd2, 8'h0F, 8'hF1, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{"sub_r0",   3'd1, 2'd0, 2'd1, 2'd2, 8'h0F, 8'hF1, 8'h1E, 1'b0, 1'b0, 8'h1E};
        vecs[2] = '{"nor_r0",   3'd5, 2'd0, 2'd0, 2'd1, 8'h1E, 8'h0F, 8'hE0, 1'b0, 1'b0, 8'hE0};
        vecs[3] = '{"illeg_r1", 3'd7, 2'd1, 2'd0, 2'd2, 8'hE0, 8'hF1, 8'h00, 1'b0, 1'b1, 8'h0F};
        vecs[4] = '{"and_r2",   3'd2, 2'd2, 2'd1, 2'd2, 8'h0F, 8'hF1, 8'h01, 1'b0, 1'b0, 8'h01};
        vecs[5] = '{"xor_r2",   3'd4, 2'd2, 2'd2, 2'd0, 8'h01, 8'hE0, 8'hE1, 1'b0, 1'b0, 8'hE1};

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_op    = '0;
        instr_rd    = '0;
        instr_rs1   = '0;
        instr_rs2   = '0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        dbg_addr    = '0;

        // Reset state
        tick();
        tick();
        check("ready_in_reset", instr_ready, 0);
        rst = 1'b0;
        #1;
        check("reset_ready", instr_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err_op", err_op, 0);
        check("reset_flag_zero", flag_zero, 0);
        check("reset_done_data", done_data, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_alu_opcode", alu_opcode, 0);
        for (int r = 0; r < 4; r++) begin
            rd_reg(r[1:0], v);
            check($sformatf("reset_reg%0d", r), v, 0);
        end

        // Table-driven single instructions
        ld(2'd1, 8'h0F);
        ld(2'd2, 8'hF1);
        for (int i = 0; i < 6; i++) begin
            run_vec(i);
        end

        // Back-to-back with instr_valid held: XOR r2=r1^r1, then OR r3=r2|r1
        set_instr(3'd4, 2'd2, 2'd1, 2'd1);
        tick();                                   // first accept
        set_instr(3'd3, 2'd3, 2'd2, 2'd1);
        check("b2b_ready_exec", instr_ready, 0);
        tick();
        check("b2b_ready_wb", instr_ready, 0);
        check("b2b_no_accept_wb", alu_opcode, 3'd4);
        tick();
        check("b2b_done1", done, 1);
        check("b2b_data1", done_data, 8'h00);
        check("b2b_flag1", flag_zero, 1);
        check("b2b_ready_idle", instr_ready, 1);
        tick();                                   // second accept, 3 cycles after first
        instr_valid = 1'b0;
        check("b2b_busy2", busy, 1);
        check("b2b_opcode2", alu_opcode, 3'd3);
        check("b2b_a2_raw", alu_a, 8'h00);
        check("b2b_b2", alu_b, 8'h0F);
        tick();
        tick();
        check("b2b_done2", done, 1);
        check("b2b_data2", done_data, 8'h0F);
        rd_reg(2'd2, v);
        check("b2b_r2", v, 8'h00);
        rd_reg(2'd3, v);
        check("b2b_r3", v, 8'h0F);
        tick();

        // Reset during EXEC drops the instruction
        ld(2'd2, 8'h33);
        set_instr(3'd0, 2'd2, 2'd1, 2'd1);
        tick();
        instr_valid = 1'b0;
        check("rst_mid_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", busy, 0);
        saw_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        check("rst_mid_no_done", saw_done, 0);
        rd_reg(2'd2, v);
        check("rst_mid_r2", v, 8'h00);
        rd_reg(2'd1, v);
        check("rst_mid_r1", v, 8'h00);

        // ld_en at the accept edge is not seen by the operand read
        ld(2'd1, 8'h55);
        set_instr(3'd3, 2'd3, 2'd1, 2'd2);
        ld_en   = 1'b1;
        ld_addr = 2'd1;
        ld_data = 8'h10;
        tick();
        instr_valid = 1'b0;
        ld_en       = 1'b0;
        check("same_edge_ld_alu_a", alu_a, 8'h55);
        tick();
        // Collision at WB edge: write-back wins
        ld_en   = 1'b1;
        ld_addr = 2'd3;
        ld_data = 8'hAA;
        tick();
        ld_en = 1'b0;
        check("collide_done", done, 1);
        check("collide_data", done_data, 8'h55);
        rd_reg(2'd3, v);
        check("collide_r3", v, 8'h55);
        rd_reg(2'd1, v);
        check("ld_r1_after", v, 8'h10);
        tick();

        // Different-address ld_en at WB edge: both writes land
        set_instr(3'd2, 2'd0, 2'd1, 2'd3);
        tick();
        instr_valid = 1'b0;
        tick();
        ld_en   = 1'b1;
        ld_addr = 2'd2;
        ld_data = 8'h99;
        tick();
        ld_en = 1'b0;
        check("diff_done", done, 1);
        rd_reg(2'd0, v);
        check("diff_r0", v, 8'h10);
        rd_reg(2'd2, v);
        check("diff_r2", v, 8'h99);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
